div_unit: RTL and testbench

- Iterative 32-bit integer divider for DIV/DIVU. It is the inverse-arithmetic companion to the combinational ALU and sits beside it in the execute stage.
- Radix-2 restoring algorithm, one quotient bit per clock.
- start/busy/ready handshake. Results are held for HI (remainder) and LO (quotient) write-back.

---
 rtl/div_unit_if.sv | 27 ++
 rtl/div_unit.sv | 135 +++++++++++++
 tb/tb_div_unit.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/div_unit_if.sv
// div_unit_if: request/result bundle for the iterative divider.
//   start/sign/dividend/divisor : request, driven by the issuing stage
//   busy/ready/q/r/dz           : status and result, driven by the divider
// master = requester (execute stage / bench), slave = div_unit.
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             sign;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             ready;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             dz;

  modport master (
    output start, sign, dividend, divisor,
    input  busy, ready, q, r, dz
  );

  modport slave (
    input  start, sign, dividend, divisor,
    output busy, ready, q, r, dz
  );
endinterface

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for DIV (signed) and DIVU.
// One quotient bit per clock. WIDTH RUN cycles after the capture edge, the
// result is presented with a one-cycle ready pulse. q (LO) and r (HI) hold
// until the next completion.
// Ports:
//   clock  : rising-edge clock
//   resetn : asynchronous active-low reset
//   bus    : div_unit_if.slave (start/sign/dividend/divisor in,
//            busy/ready/q/r/dz out)
// Parameters:
//   WIDTH : operand/result width, also the iteration count
//   CW    : iteration counter width, 2**CW >= WIDTH
module div_unit #(
  parameter int WIDTH = 32,
  parameter int CW    = 5
) (
  input  logic       clock,
  input  logic       resetn,
  div_unit_if.slave  bus
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_q;    // partial remainder
  logic [WIDTH-1:0] quo_q;    // dividend bits shifting out, quotient bits in
  logic [WIDTH-1:0] dvs_q;    // divisor magnitude
  logic             qneg_q;
  logic             rneg_q;
  logic             busy_q;
  logic             ready_q;
  logic             dz_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] r_q;

  logic [WIDTH:0]   trial_w;
  logic [WIDTH:0]   diff_w;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] quo_d;
  logic [WIDTH-1:0] q_fin;
  logic [WIDTH-1:0] r_fin;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             a_msb;
  logic             b_msb;
  logic             last_w;

  always_comb begin
    // Shift the next dividend bit into the partial remainder; the extra top
    // bit of the WIDTH+1 subtraction is the borrow that decides restore.
    trial_w = {rem_q, quo_q[WIDTH-1]};
    diff_w  = trial_w - {1'b0, dvs_q};
    if (!diff_w[WIDTH]) begin
      rem_d = diff_w[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_d = trial_w[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b0};
    end
    q_fin = qneg_q ? (~quo_d + 1'b1) : quo_d;
    r_fin = rneg_q ? (~rem_d + 1'b1) : rem_d;

    // Magnitudes at capture. The most negative value maps onto itself, which
    // read as unsigned is the correct magnitude, so overflow needs no case.
    a_msb = bus.dividend[WIDTH-1];
    b_msb = bus.divisor[WIDTH-1];
    a_mag = (bus.sign && a_msb) ? (~bus.dividend + 1'b1) : bus.dividend;
    b_mag = (bus.sign && b_msb) ? (~bus.divisor  + 1'b1) : bus.divisor;

    last_w = (cnt_q == CW'(WIDTH - 1));
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      dz_q    <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (bus.divisor == '0) begin
              // Divide-by-zero completes on the capture edge, no iterations.
              q_q     <= '1;
              r_q     <= bus.dividend;
              dz_q    <= 1'b1;
              ready_q <= 1'b1;
            end else begin
              quo_q   <= a_mag;
              dvs_q   <= b_mag;
              rem_q   <= '0;
              qneg_q  <= bus.sign & (a_msb ^ b_msb);
              rneg_q  <= bus.sign & a_msb;
              cnt_q   <= '0;
              busy_q  <= 1'b1;
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + CW'(1);
          if (last_w) begin
            q_q     <= q_fin;
            r_q     <= r_fin;
            dz_q    <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.ready = ready_q;
  assign bus.q     = q_q;
  assign bus.r     = r_q;
  assign bus.dz    = dz_q;

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;
  logic clock;
  logic resetn;
  int   vectors;
  int   miscompares;

  div_unit_if #(.WIDTH(32)) bus ();

  div_unit #(.WIDTH(32), .CW(5)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Present a request for one edge (E0), then release start and scramble the
  // operand inputs so that capture is actually exercised.
  task automatic do_start(input logic sg, input logic [31:0] a, input logic [31:0] b);
    bus.start    = 1'b1;
    bus.sign     = sg;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clock);
    #1;
    bus.start    = 1'b0;
    bus.sign     = ~sg;
    bus.dividend = 32'hDEAD_BEEF;
    bus.divisor  = 32'h0000_0001;
  endtask

  // Step edges until ready is seen (bounded); reports edges and busy cycles.
  task automatic wait_ready(output int cyc, output int nbusy);
    cyc   = 0;
    nbusy = 0;
    do begin
      if (bus.busy === 1'b1) nbusy++;
      @(posedge clock);
      #1;
      cyc++;
    end while (bus.ready !== 1'b1 && cyc < 100);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    bus.start = 1'b0; bus.sign = 1'b0; bus.dividend = '0; bus.divisor = '0;
    repeat (3) @(posedge clock);
    #1;
    vectors++;
    if ({bus.busy, bus.ready, bus.q, bus.r, bus.dz} !== 67'd0) begin
      miscompares++;
      $display("FAIL reset_state: busy=%b ready=%b q=%h r=%h dz=%b, want all zero",
               bus.busy, bus.ready, bus.q, bus.r, bus.dz);
    end
    resetn = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic test_unsigned();
    int cyc, nb;
    do_start(1'b0, 32'd100, 32'd7);
    vectors++;
    if (bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL u_busy_after_start: busy=%b want 1", bus.busy);
    end
    wait_ready(cyc, nb);
    vectors++;
    if (cyc !== 32 || nb !== 32) begin
      miscompares++;
      $display("FAIL u_latency: edges=%0d busy_cycles=%0d want 32/32", cyc, nb);
    end
    vectors++;
    if ({bus.q, bus.r, bus.dz, bus.busy} !== {32'd14, 32'd2, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL u_100_7: q=%h r=%h dz=%b busy=%b want q=0000000e r=00000002 dz=0 busy=0",
               bus.q, bus.r, bus.dz, bus.busy);
    end
    @(posedge clock);
    #1;
    vectors++;
    if (bus.ready !== 1'b0 || bus.q !== 32'd14) begin
      miscompares++;
      $display("FAIL u_ready_pulse: ready=%b q=%h want ready=0 q held 0000000e", bus.ready, bus.q);
    end
  endtask

  task automatic test_signed();
    int cyc, nb;
    logic [31:0] a [3] = '{32'hFFFF_FFF9, 32'd7,          32'hFFFF_FF9C};
    logic [31:0] b [3] = '{32'd2,         32'hFFFF_FFFE, 32'hFFFF_FFF9};
    logic [31:0] eq[3] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'd14};
    logic [31:0] er[3] = '{32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFE};
    for (int i = 0; i < 3; i++) begin
      do_start(1'b1, a[i], b[i]);
      wait_ready(cyc, nb);
      vectors++;
      if (cyc !== 32 || {bus.q, bus.r, bus.dz} !== {eq[i], er[i], 1'b0}) begin
        miscompares++;
        $display("FAIL signed_%0d: edges=%0d q=%h r=%h dz=%b want edges=32 q=%h r=%h dz=0",
                 i, cyc, bus.q, bus.r, bus.dz, eq[i], er[i]);
      end
    end
  endtask

  task automatic test_div_zero();
    int cyc, nb;
    do_start(1'b0, 32'd5, 32'd0);
    vectors++;
    if ({bus.ready, bus.busy, bus.q, bus.r, bus.dz} !== {1'b1, 1'b0, 32'hFFFF_FFFF, 32'd5, 1'b1}) begin
      miscompares++;
      $display("FAIL dz_u_5_0: ready=%b busy=%b q=%h r=%h dz=%b want 1 0 ffffffff 00000005 1",
               bus.ready, bus.busy, bus.q, bus.r, bus.dz);
    end
    // Second divide-by-zero in the ready cycle keeps ready high.
    do_start(1'b1, 32'hFFFF_FFFB, 32'd0);
    vectors++;
    if ({bus.ready, bus.busy, bus.q, bus.r, bus.dz} !== {1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1}) begin
      miscompares++;
      $display("FAIL dz_s_back2back: ready=%b busy=%b q=%h r=%h dz=%b want 1 0 ffffffff fffffffb 1",
               bus.ready, bus.busy, bus.q, bus.r, bus.dz);
    end
    @(posedge clock);
    #1;
    vectors++;
    if (bus.ready !== 1'b0 || bus.dz !== 1'b1) begin
      miscompares++;
      $display("FAIL dz_ready_drop: ready=%b dz=%b want ready=0 dz=1", bus.ready, bus.dz);
    end
    do_start(1'b0, 32'd9, 32'd3);
    wait_ready(cyc, nb);
    vectors++;
    if ({bus.q, bus.r, bus.dz} !== {32'd3, 32'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL dz_then_9_3: q=%h r=%h dz=%b want 00000003 00000000 0", bus.q, bus.r, bus.dz);
    end
  endtask

  task automatic test_overflow();
    int cyc, nb;
    do_start(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_ready(cyc, nb);
    vectors++;
    if ({bus.q, bus.r, bus.dz} !== {32'h8000_0000, 32'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL ovf_signed: q=%h r=%h dz=%b want 80000000 00000000 0", bus.q, bus.r, bus.dz);
    end
    do_start(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_ready(cyc, nb);
    vectors++;
    if ({bus.q, bus.r, bus.dz} !== {32'd0, 32'h8000_0000, 1'b0}) begin
      miscompares++;
      $display("FAIL ovf_unsigned: q=%h r=%h dz=%b want 00000000 80000000 0", bus.q, bus.r, bus.dz);
    end
  endtask

  // Start while busy is ignored; start in the ready cycle is accepted.
  task automatic test_back_to_back();
    int cyc, nb;
    do_start(1'b0, 32'd1000, 32'd3);
    repeat (9) @(posedge clock);
    #1;
    bus.start = 1'b1; bus.sign = 1'b0; bus.dividend = 32'd50; bus.divisor = 32'd5;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    wait_ready(cyc, nb);
    vectors++;
    if (cyc !== 22 || {bus.q, bus.r, bus.dz} !== {32'd333, 32'd1, 1'b0}) begin
      miscompares++;
      $display("FAIL busy_ignore: edges=%0d q=%h r=%h dz=%b want edges=22 q=0000014d r=00000001 dz=0",
               cyc, bus.q, bus.r, bus.dz);
    end
    do_start(1'b0, 32'd50, 32'd5);
    vectors++;
    if (bus.ready !== 1'b0 || bus.busy !== 1'b1 || bus.q !== 32'd333) begin
      miscompares++;
      $display("FAIL b2b_accept: ready=%b busy=%b q=%h want 0 1 0000014d", bus.ready, bus.busy, bus.q);
    end
    wait_ready(cyc, nb);
    vectors++;
    if (cyc !== 32 || {bus.q, bus.r, bus.dz} !== {32'd10, 32'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL b2b_50_5: edges=%0d q=%h r=%h dz=%b want edges=32 q=0000000a r=00000000 dz=0",
               cyc, bus.q, bus.r, bus.dz);
    end
  endtask

  task automatic test_midrun_reset();
    int cyc, nb, pulses;
    do_start(1'b0, 32'd1000, 32'd3);
    repeat (15) @(posedge clock);
    #1;
    resetn = 1'b0;
    #1;
    vectors++;
    if ({bus.busy, bus.ready, bus.q, bus.r, bus.dz} !== 67'd0) begin
      miscompares++;
      $display("FAIL midrun_reset: busy=%b ready=%b q=%h r=%h dz=%b want all zero",
               bus.busy, bus.ready, bus.q, bus.r, bus.dz);
    end
    repeat (2) @(posedge clock);
    #1;
    resetn = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (bus.ready === 1'b1 || bus.busy === 1'b1) pulses++;
    end
    vectors++;
    if (pulses !== 0) begin
      miscompares++;
      $display("FAIL reset_abort: ready/busy seen %0d cycles after reset, want 0", pulses);
    end
    do_start(1'b0, 32'd100, 32'd7);
    wait_ready(cyc, nb);
    vectors++;
    if (cyc !== 32 || {bus.q, bus.r, bus.dz} !== {32'd14, 32'd2, 1'b0}) begin
      miscompares++;
      $display("FAIL restart_100_7: edges=%0d q=%h r=%h dz=%b want edges=32 q=0000000e r=00000002 dz=0",
               cyc, bus.q, bus.r, bus.dz);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_back_to_back();
    test_midrun_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
